// File: rtl/br_pkg.sv
// Branch control shared types: FSM states, queue depth, recovery length
// and the in-flight entry record.
package br_pkg;

  localparam int QDEPTH      = 2;
  localparam int RECOVER_CYC = 2;

  typedef enum logic {
    RUN     = 1'b0,
    RECOVER = 1'b1
  } br_state_e;

  typedef struct packed {
    logic        pred;
    logic [31:0] alt_pc;
  } br_entry_t;

endpackage

// File: rtl/br_inflight_fifo.sv
// In-flight branch queue. Ports: cpu_clk/cpu_rst, clear (wins over push),
// push/pop with din, full/empty flags and head entry.
module br_inflight_fifo
  import br_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic      cpu_clk,
  input  logic      cpu_rst,
  input  logic      clear,
  input  logic      push,
  input  logic      pop,
  input  br_entry_t din,
  output logic      full,
  output logic      empty,
  output br_entry_t head
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  br_entry_t      mem [DEPTH];
  logic [AW-1:0]  rd_ptr;
  logic [AW-1:0]  wr_ptr;
  logic [AW:0]    count;
  logic           push_ok;
  logic           pop_ok;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign head    = mem[rd_ptr];

  function automatic logic [AW-1:0] inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge cpu_clk) begin
    if (push_ok && !clear && !cpu_rst)
      mem[wr_ptr] <= din;
  end

  always_ff @(posedge cpu_clk) begin
    if (cpu_rst || clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= inc(wr_ptr);
      if (pop_ok)  rd_ptr <= inc(rd_ptr);
      unique case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/br_ctrl.sv
// Branch resolution control: in-flight queue, mispredict detect, redirect
// mux, recovery FSM, counters and sticky queue error flags.
module br_ctrl
  import br_pkg::*;
(
  input  logic        cpu_clk,
  input  logic        cpu_rst,
  input  logic        id_is_B,
  input  logic        id_pre_br,
  input  logic [31:0] id_target,
  input  logic [31:0] id_pc4,
  input  logic        stall,
  input  logic        ex_valid_B,
  input  logic        ex_real_br,
  output logic        upd_en,
  output logic        upd_taken,
  output logic        redirect,
  output logic [31:0] redirect_pc,
  output logic        flush,
  output logic [15:0] br_cnt,
  output logic [15:0] mispred_cnt,
  output logic        q_ovf,
  output logic        q_unf
);

  br_state_e  state;
  br_state_e  state_n;
  logic [1:0] rcnt;
  logic [1:0] rcnt_n;

  logic       run;
  logic       push_req;
  logic       pop;
  logic       mispred;
  logic       q_full;
  logic       q_empty;
  br_entry_t  q_head;
  br_entry_t  q_din;

  // Gating with reset forces every strobe and redirect low during reset.
  assign run      = (state == RUN) & ~cpu_rst;
  assign pop      = ex_valid_B & ~q_empty & run;
  assign mispred  = pop & (q_head.pred != ex_real_br);
  assign push_req = id_is_B & ~stall & ~mispred & run;

  assign q_din.pred   = id_pre_br;
  assign q_din.alt_pc = id_pre_br ? id_pc4 : id_target;

  br_inflight_fifo #(
    .DEPTH (QDEPTH)
  ) u_fifo (
    .cpu_clk (cpu_clk),
    .cpu_rst (cpu_rst),
    .clear   (mispred),
    .push    (push_req),
    .pop     (pop),
    .din     (q_din),
    .full    (q_full),
    .empty   (q_empty),
    .head    (q_head)
  );

  assign upd_en    = pop;
  assign upd_taken = ex_real_br;
  assign flush     = mispred;

  always_comb begin
    redirect    = 1'b0;
    redirect_pc = '0;
    if (mispred) begin
      redirect    = 1'b1;
      redirect_pc = q_head.alt_pc;
    end else if (push_req && id_pre_br) begin
      redirect    = 1'b1;
      redirect_pc = id_target;
    end
  end

  always_comb begin
    state_n = state;
    rcnt_n  = rcnt;
    unique case (state)
      RUN: begin
        if (mispred) begin
          state_n = RECOVER;
          rcnt_n  = 2'(RECOVER_CYC);
        end
      end
      RECOVER: begin
        if (rcnt <= 2'd1) begin
          state_n = RUN;
          rcnt_n  = '0;
        end else begin
          rcnt_n  = rcnt - 1'b1;
        end
      end
      default: begin
        state_n = RUN;
        rcnt_n  = '0;
      end
    endcase
  end

  always_ff @(posedge cpu_clk) begin
    if (cpu_rst) begin
      state       <= RUN;
      rcnt        <= '0;
      br_cnt      <= '0;
      mispred_cnt <= '0;
      q_ovf       <= 1'b0;
      q_unf       <= 1'b0;
    end else begin
      state <= state_n;
      rcnt  <= rcnt_n;
      if (pop && br_cnt != 16'hFFFF)
        br_cnt <= br_cnt + 1'b1;
      if (mispred && mispred_cnt != 16'hFFFF)
        mispred_cnt <= mispred_cnt + 1'b1;
      if (push_req && q_full)
        q_ovf <= 1'b1;
      if (ex_valid_B && q_empty && run)
        q_unf <= 1'b1;
    end
  end

endmodule
